irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt request front-end that sits directly upstream of the fetch stage and drives its interrupts[3:0] input.
- Synchronises four asynchronous external request lines, detects edges or levels per line, and latches pending requests under a software mask.
- Picks one request by fixed priority (line 0 highest, same order as fetch) and issues it as a single-cycle one-hot pulse.
- Tracks the request through acknowledge (int_en1 from fetch) and return-from-interrupt (rti) before issuing the next one.

Parameters:
SYNC_STAGES, 2, synchroniser depth per line; legal range 2..3
EDGE_MODE, 4'b1111, per line: 1 = rising-edge sensitive, 0 = level sensitive

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
irq_in  input  4  asynchronous external interrupt lines
mask_we  input  1  write strobe for the mask register
mask_wdata  input  4  new mask value; 1 = line disabled
int_ack  input  1  handler entry taken; driven by fetch int_en1
rti  input  1  return from interrupt, from decode
interrupts  output  4  one-hot, single-cycle request pulse to fetch; registered
mask  output  4  current mask register
pending  output  4  pending latches
active  output  1  high while in WAIT_ACK or IN_SERVICE
active_id  output  2  index of the issued or in-service line
overrun  output  4  sticky: event arrived while that line was already pending
ovf_clr  input  1  clears all overrun bits

Behaviour:
- Reset (asynchronous): all synchroniser flops, edge-history flops, pending, mask, overrun, interrupts, active and active_id go to 0; FSM goes to IDLE.
- Synchroniser: SYNC_STAGES flops per line. The last stage is s[i]; prev[i] is s[i] delayed by one clock.
- Event detection:
  - Edge mode: event[i] = s[i] & ~prev[i].
  - Level mode: event[i] = s[i], evaluated every cycle.
- Pending: pending[i] is set on event[i] regardless of mask. It is cleared only when line i is issued. If set and clear occur in the same cycle, set wins.
- Overrun: overrun[i] is set when event[i] occurs while pending[i] is already 1 and pending[i] is not being cleared that cycle. This applies to edge-mode lines only; level mode never sets overrun. ovf_clr clears all bits; a simultaneous set wins.
- Mask:
  - mask_we loads mask_wdata at the clock edge.
  - The new value affects selection from the next cycle onward.
  - Masked lines stay pending and issue once unmasked.
- Eligibility: eligible = pending & ~mask. sel is the lowest-index eligible bit.
- FSM:
  - IDLE: if eligible != 0, go to ISSUE. Latch active_id = sel, clear pending[sel], set interrupts <= one-hot(sel). Otherwise stay in IDLE with interrupts = 0.
  - ISSUE (exactly one cycle; interrupts holds the one-hot value): next interrupts <= 0; go to WAIT_ACK.
  - WAIT_ACK: go to IN_SERVICE on int_ack; go to IDLE on rti (aborted or spurious handler).
  - IN_SERVICE: go to IDLE on rti; int_ack is ignored.
  - rti is ignored in IDLE and ISSUE.
- active = 1 in WAIT_ACK and IN_SERVICE. active_id holds its value until the next issue.
- Only one request is outstanding at a time. No nesting; higher-priority events wait in pending.
- Latency (SYNC_STAGES = 2): irq_in is first sampled high at clock edge k.
  - pending[i] is set at edge k+2.
  - ISSUE is entered at edge k+3, and interrupts[i] is high for the single cycle k+3..k+4.
  - Back-to-back: the earliest next issue is the cycle after rti returns the FSM to IDLE.
- Reset mid-operation returns to IDLE immediately and drops all pending, with no pulse emitted afterward.

Test Plan:
1. Reset, mask = 0, raise irq_in[2] (edge) at edge 10 -> pending = 4'b0100 at edge 12; interrupts = 4'b0100 for exactly one cycle from edge 13; active_id = 2. Then int_ack -> IN_SERVICE; rti -> IDLE, active = 0.
2. Raise irq_in[3] and irq_in[1] in the same cycle -> line 1 issues first (interrupts = 4'b0010). After int_ack and rti, line 3 issues (4'b1000); pending = 0 at the end.
3. mask = 4'b0001, pulse irq_in[0] -> pending[0] = 1, no interrupts pulse. Write mask = 0 -> 4'b0001 is issued on the second cycle after the write edge.
4. While line 0 is in service, pulse irq_in[0] twice -> after the first pulse pending[0] = 1; the second pulse sets overrun[0] = 1 and leaves pending[0] = 1. ovf_clr -> overrun = 0.
5. EDGE_MODE = 4'b1110, hold irq_in[0] high -> line 0 re-issues after every rti (0 → 1 → 1 ...); overrun never set.
6. Assert reset in IN_SERVICE with pending = 4'b1010 -> all outputs 0 immediately. Release reset with inputs low -> no interrupts pulse for 20 cycles.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt request front-end for the fetch stage.
//
// Synchronises four asynchronous request lines and detects an edge or a level
// on each one. Detected requests are latched as pending. The lowest-index
// pending line that is not masked is issued to fetch as a one-hot pulse that
// lasts a single cycle. The request is then tracked through acknowledge and
// return-from-interrupt. Only after that is the next request issued.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   irq_in     asynchronous external interrupt lines
//   mask_we    mask register write strobe
//   mask_wdata new mask value (1 = line disabled)
//   int_ack    handler entry taken (fetch int_en1)
//   rti        return from interrupt (decode)
//   ovf_clr    clears all overrun bits
//   interrupts registered one-hot request pulse to fetch
//   mask       current mask register
//   pending    pending latches
//   active     high while waiting for ack or in service
//   active_id  index of the issued / in-service line
//   overrun    sticky: event arrived while that line was already pending
module irq_controller #(
  parameter int unsigned SYNC_STAGES = 2,       // legal range 2..3
  parameter logic [3:0]  EDGE_MODE   = 4'b1111  // 1 = rising edge, 0 = level
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       int_ack,
  input  logic       rti,
  input  logic       ovf_clr,
  output logic [3:0] interrupts,
  output logic [3:0] mask,
  output logic [3:0] pending,
  output logic       active,
  output logic [1:0] active_id,
  output logic [3:0] overrun
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StInService} state_e;

  state_e     state_q, state_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_s;
  logic [3:0] prev_q;
  logic [3:0] evt;
  logic [3:0] pending_q, pending_d;
  logic [3:0] overrun_q, overrun_d;
  logic [3:0] mask_q;
  logic [3:0] interrupts_q, interrupts_d;
  logic [1:0] active_id_q;
  logic [3:0] eligible;
  logic [1:0] sel;
  logic       issue;

  // Synchroniser chain plus one cycle of edge history per line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < int'(SYNC_STAGES); j++) sync_q[j] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int j = 1; j < int'(SYNC_STAGES); j++) sync_q[j] <= sync_q[j-1];
      prev_q <= sync_s;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign evt    = (sync_s & ~prev_q & EDGE_MODE) | (sync_s & ~EDGE_MODE);

  assign eligible = pending_q & ~mask_q;

  // Fixed priority: line 0 wins.
  always_comb begin
    sel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) sel = 2'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (|eligible) state_d = StIssue;
      StIssue:     state_d = StWaitAck;
      // rti wins over a same-cycle ack: the handler is treated as finished.
      StWaitAck: begin
        if (rti)          state_d = StIdle;
        else if (int_ack) state_d = StInService;
      end
      StInService: if (rti) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    issue        = (state_q == StIdle) && (|eligible);
    active       = (state_q == StWaitAck) || (state_q == StInService);
    interrupts_d = issue ? (4'b0001 << sel) : 4'b0000;
  end

  // A new event beats the clear on issue, so a held level line stays pending.
  always_comb begin
    pending_d = (pending_q & ~interrupts_d) | evt;
    overrun_d = (ovf_clr ? 4'b0000 : overrun_q)
              | (evt & EDGE_MODE & pending_q & ~interrupts_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      overrun_q    <= '0;
      mask_q       <= '0;
      interrupts_q <= '0;
      active_id_q  <= '0;
    end else begin
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      interrupts_q <= interrupts_d;
      if (mask_we) mask_q <= mask_wdata;
      if (issue)   active_id_q <= sel;
    end
  end

  assign interrupts = interrupts_q;
  assign mask       = mask_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign active_id  = active_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: one default (all-edge) instance and one
// instance with line 0 level sensitive, sharing every input.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       int_ack;
  logic       rti;
  logic       ovf_clr;

  logic [3:0] interrupts, mask, pending, overrun;
  logic       active;
  logic [1:0] active_id;

  logic [3:0] l_interrupts, l_mask, l_pending, l_overrun;
  logic       l_active;
  logic [1:0] l_active_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .rti        (rti),
    .ovf_clr    (ovf_clr),
    .interrupts (interrupts),
    .mask       (mask),
    .pending    (pending),
    .active     (active),
    .active_id  (active_id),
    .overrun    (overrun)
  );

  irq_controller #(.SYNC_STAGES(2), .EDGE_MODE(4'b1110)) dut_lvl (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .rti        (rti),
    .ovf_clr    (ovf_clr),
    .interrupts (l_interrupts),
    .mask       (l_mask),
    .pending    (l_pending),
    .active     (l_active),
    .active_id  (l_active_id),
    .overrun    (l_overrun)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    int_ack = 1'b0; rti = 1'b0; ovf_clr = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({interrupts, mask, pending, active, active_id, overrun} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b",
               {interrupts, mask, pending, active, active_id, overrun}, 19'd0);
    end
  endtask

  // Line 2 edge: pending at k+2, pulse k+3..k+4, then ack / rti.
  task automatic test_single();
    irq_in = 4'b0100;
    cyc(1);  // after edge k
    irq_in = 4'b0000;
    cyc(1);  // after k+1
    checks++;
    if (pending !== 4'b0000) begin
      errors++; $display("FAIL t1_pend_k1 got=%b exp=%b", pending, 4'b0000);
    end
    cyc(1);  // after k+2
    checks++;
    if ({pending, interrupts} !== 8'b0100_0000) begin
      errors++; $display("FAIL t1_pend_k2 got=%b exp=%b", {pending, interrupts}, 8'b0100_0000);
    end
    cyc(1);  // after k+3
    checks++;
    if ({interrupts, pending, active, active_id} !== 11'b0100_0000_0_10) begin
      errors++;
      $display("FAIL t1_issue got=%b exp=%b", {interrupts, pending, active, active_id},
               11'b0100_0000_0_10);
    end
    cyc(1);  // after k+4
    checks++;
    if ({interrupts, active} !== 5'b0000_1) begin
      errors++; $display("FAIL t1_one_cycle got=%b exp=%b", {interrupts, active}, 5'b0000_1);
    end
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    cyc(1);
    checks++;
    if ({active, active_id} !== 3'b1_10) begin
      errors++; $display("FAIL t1_in_service got=%b exp=%b", {active, active_id}, 3'b1_10);
    end
    rti = 1'b1;
    cyc(1);
    rti = 1'b0;
    checks++;
    if ({active, active_id, interrupts} !== 7'b0_10_0000) begin
      errors++;
      $display("FAIL t1_rti got=%b exp=%b", {active, active_id, interrupts}, 7'b0_10_0000);
    end
  endtask

  // Lines 3 and 1 together: 1 first, 3 right after rti.
  task automatic test_priority();
    irq_in = 4'b1010;
    cyc(1);
    irq_in = 4'b0000;
    cyc(3);  // after k+3
    checks++;
    if ({interrupts, pending, active_id} !== 10'b0010_1000_01) begin
      errors++;
      $display("FAIL t2_first got=%b exp=%b", {interrupts, pending, active_id},
               10'b0010_1000_01);
    end
    cyc(1);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    rti = 1'b1;
    cyc(1);  // after rti edge r
    rti = 1'b0;
    checks++;
    if ({interrupts, active} !== 5'b0000_0) begin
      errors++; $display("FAIL t2_idle got=%b exp=%b", {interrupts, active}, 5'b0000_0);
    end
    cyc(1);  // after r+1
    checks++;
    if ({interrupts, pending, active_id} !== 10'b1000_0000_11) begin
      errors++;
      $display("FAIL t2_second got=%b exp=%b", {interrupts, pending, active_id},
               10'b1000_0000_11);
    end
    cyc(1);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    rti = 1'b1;
    cyc(1);
    rti = 1'b0;
    checks++;
    if ({pending, active} !== 5'b0000_0) begin
      errors++; $display("FAIL t2_end got=%b exp=%b", {pending, active}, 5'b0000_0);
    end
  endtask

  // Masked line stays pending; issues the second cycle after unmask.
  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b0001;
    cyc(1);
    mask_we = 1'b0;
    checks++;
    if (mask !== 4'b0001) begin
      errors++; $display("FAIL t3_mask_wr got=%b exp=%b", mask, 4'b0001);
    end
    irq_in = 4'b0001;
    cyc(1);
    irq_in = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      cyc(1);
      checks++;
      if ({interrupts, active} !== 5'b0000_0) begin
        errors++;
        $display("FAIL t3_masked_c%0d got=%b exp=%b", c, {interrupts, active}, 5'b0000_0);
      end
    end
    checks++;
    if (pending !== 4'b0001) begin
      errors++; $display("FAIL t3_pend got=%b exp=%b", pending, 4'b0001);
    end
    mask_we = 1'b1; mask_wdata = 4'b0000;
    cyc(1);  // after write edge w
    mask_we = 1'b0;
    checks++;
    if ({mask, interrupts} !== 8'b0000_0000) begin
      errors++; $display("FAIL t3_w0 got=%b exp=%b", {mask, interrupts}, 8'b0000_0000);
    end
    cyc(1);  // after w+1
    checks++;
    if ({interrupts, active_id} !== 6'b0001_00) begin
      errors++; $display("FAIL t3_w1 got=%b exp=%b", {interrupts, active_id}, 6'b0001_00);
    end
  endtask

  // Continues with line 0 issued from test_mask.
  task automatic test_overrun();
    cyc(1);  // WAIT_ACK
    int_ack = 1'b1;
    cyc(1);  // IN_SERVICE
    int_ack = 1'b0;
    irq_in = 4'b0001;
    cyc(1);
    irq_in = 4'b0000;
    cyc(3);
    checks++;
    if ({pending, overrun, active} !== 9'b0001_0000_1) begin
      errors++;
      $display("FAIL t4_first got=%b exp=%b", {pending, overrun, active}, 9'b0001_0000_1);
    end
    irq_in = 4'b0001;
    cyc(1);
    irq_in = 4'b0000;
    cyc(3);
    checks++;
    if ({pending, overrun} !== 8'b0001_0001) begin
      errors++; $display("FAIL t4_second got=%b exp=%b", {pending, overrun}, 8'b0001_0001);
    end
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    checks++;
    if ({pending, overrun} !== 8'b0001_0000) begin
      errors++; $display("FAIL t4_clr got=%b exp=%b", {pending, overrun}, 8'b0001_0000);
    end
    rti = 1'b1;
    cyc(1);
    rti = 1'b0;
    cyc(1);
    checks++;
    if ({interrupts, pending} !== 8'b0001_0000) begin
      errors++; $display("FAIL t4_reissue got=%b exp=%b", {interrupts, pending}, 8'b0001_0000);
    end
    cyc(1);
    // rti straight from WAIT_ACK aborts back to IDLE.
    rti = 1'b1;
    cyc(1);
    rti = 1'b0;
    checks++;
    if ({active, interrupts} !== 5'b0_0000) begin
      errors++; $display("FAIL t4_abort got=%b exp=%b", {active, interrupts}, 5'b0_0000);
    end
  endtask

  // Level-sensitive line 0 held high re-issues after every rti.
  task automatic test_level();
    do_reset();
    irq_in = 4'b0001;
    cyc(4);  // after k+3
    checks++;
    if ({l_interrupts, l_pending, l_overrun} !== 12'b0001_0001_0000) begin
      errors++;
      $display("FAIL t5_first got=%b exp=%b", {l_interrupts, l_pending, l_overrun},
               12'b0001_0001_0000);
    end
    cyc(1);
    for (int r = 0; r < 3; r++) begin
      int_ack = 1'b1;
      cyc(1);
      int_ack = 1'b0;
      rti = 1'b1;
      cyc(1);
      rti = 1'b0;
      cyc(1);
      checks++;
      if ({l_interrupts, l_overrun} !== 8'b0001_0000) begin
        errors++;
        $display("FAIL t5_reissue_%0d got=%b exp=%b", r, {l_interrupts, l_overrun},
                 8'b0001_0000);
      end
      cyc(1);
    end
    irq_in = 4'b0000;
  endtask

  // Async reset while in service with lines pending.
  task automatic test_reset_mid();
    do_reset();
    irq_in = 4'b0001;
    cyc(1);
    irq_in = 4'b0000;
    cyc(4);  // WAIT_ACK
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    irq_in = 4'b1010;
    cyc(1);
    irq_in = 4'b0000;
    cyc(3);
    checks++;
    if ({pending, active} !== 5'b1010_1) begin
      errors++; $display("FAIL t6_setup got=%b exp=%b", {pending, active}, 5'b1010_1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({interrupts, mask, pending, active, active_id, overrun} !== 19'd0) begin
      errors++;
      $display("FAIL t6_async got=%b exp=%b",
               {interrupts, mask, pending, active, active_id, overrun}, 19'd0);
    end
    cyc(1);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      checks++;
      if ({interrupts, pending, active} !== 9'd0) begin
        errors++;
        $display("FAIL t6_quiet_c%0d got=%b exp=%b", c, {interrupts, pending, active}, 9'd0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_overrun();
    test_level();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
